// File: rtl/udp_tx_packer.sv
// Single-packet staging buffer: packs a byte stream big-endian into 32-bit words,
// then serves them to the UDP transmit stage on request until done or timeout.
module udp_tx_packer #(
  parameter int          ADDR_W      = 8,
  parameter logic [31:0] TIMEOUT_CYC = 32'd1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  input  logic        wr_last,
  output logic        wr_ready,
  output logic        tx_start_en,
  output logic [15:0] tx_byte_num,
  input  logic        tx_req,
  output logic [31:0] tx_data,
  input  logic        tx_done,
  output logic        busy,
  output logic        pkt_sent,
  output logic        timeout_err
);

  localparam logic [1:0]      S_FILL  = 2'd0;
  localparam logic [1:0]      S_START = 2'd1;
  localparam logic [1:0]      S_SEND  = 2'd2;
  localparam logic [ADDR_W:0] CAP     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [31:0]     TO_LAST = TIMEOUT_CYC - 32'd1;

  logic [31:0]     r_mem [2**ADDR_W];
  logic [1:0]      r_state;
  logic [ADDR_W:0] r_wr_ptr;
  logic [ADDR_W:0] r_rd_ptr;
  logic [15:0]     r_byte_cnt;
  logic [31:0]     r_pack;
  logic [15:0]     r_byte_num;
  logic [31:0]     r_tx_data;
  logic [31:0]     r_to_cnt;
  logic            r_pkt_sent;
  logic            r_timeout;

  logic            w_wr_ready;
  logic            w_accept;
  logic            w_word_done;
  logic [4:0]      w_shift;
  logic [31:0]     w_pack_next;

  // wr_ptr == CAP means every word slot is committed and nothing is pending
  assign w_wr_ready  = (r_state == S_FILL) && (r_wr_ptr != CAP);
  assign w_accept    = wr_en && w_wr_ready;
  assign w_word_done = w_accept && ((r_byte_cnt[1:0] == 2'd3) || wr_last);
  assign w_shift     = 5'd24 - {r_byte_cnt[1:0], 3'b000};
  assign w_pack_next = r_pack | ({24'd0, wr_data} << w_shift);

  assign wr_ready    = w_wr_ready;
  assign tx_start_en = (r_state == S_START);
  assign busy        = (r_state != S_FILL);
  assign tx_byte_num = r_byte_num;
  assign tx_data     = r_tx_data;
  assign pkt_sent    = r_pkt_sent;
  assign timeout_err = r_timeout;

  always_ff @(posedge clk) begin
    if (w_word_done) r_mem[r_wr_ptr[ADDR_W-1:0]] <= w_pack_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_FILL;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_byte_cnt <= '0;
      r_pack     <= '0;
      r_byte_num <= '0;
      r_tx_data  <= '0;
      r_to_cnt   <= '0;
      r_pkt_sent <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_pkt_sent <= 1'b0;
      r_timeout  <= 1'b0;
      case (r_state)
        S_FILL: begin
          if (w_accept) begin
            r_byte_cnt <= r_byte_cnt + 16'd1;
            if (w_word_done) begin
              r_wr_ptr <= r_wr_ptr + PTR_ONE;
              r_pack   <= '0;
            end else begin
              r_pack   <= w_pack_next;
            end
            if (wr_last) begin
              r_byte_num <= r_byte_cnt + 16'd1;
              r_state    <= S_START;
            end else begin
              r_byte_num <= '0;
            end
          end
        end
        S_START: begin
          r_rd_ptr <= '0;
          r_to_cnt <= '0;
          r_state  <= S_SEND;
        end
        S_SEND: begin
          // done outranks both timeout and a coincident word request
          if (tx_done || (r_to_cnt == TO_LAST)) begin
            r_pkt_sent <= tx_done;
            r_timeout  <= !tx_done;
            r_state    <= S_FILL;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_byte_cnt <= '0;
            r_to_cnt   <= '0;
          end else begin
            r_to_cnt <= r_to_cnt + 32'd1;
            if (tx_req) begin
              if (r_rd_ptr < r_wr_ptr) begin
                r_tx_data <= r_mem[r_rd_ptr[ADDR_W-1:0]];
                r_rd_ptr  <= r_rd_ptr + PTR_ONE;
              end else begin
                r_tx_data <= '0;
              end
            end
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_packer.sv
// Directed bench for udp_tx_packer with a 4-word buffer and a 20-cycle timeout.
module tb_udp_tx_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = 8'd0;
  logic        wr_last = 1'b0;
  logic        wr_ready;
  logic        tx_start_en;
  logic [15:0] tx_byte_num;
  logic        tx_req = 1'b0;
  logic [31:0] tx_data;
  logic        tx_done = 1'b0;
  logic        busy;
  logic        pkt_sent;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  udp_tx_packer #(.ADDR_W(2), .TIMEOUT_CYC(32'd20)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .wr_last(wr_last),
    .wr_ready(wr_ready), .tx_start_en(tx_start_en), .tx_byte_num(tx_byte_num),
    .tx_req(tx_req), .tx_data(tx_data), .tx_done(tx_done), .busy(busy),
    .pkt_sent(pkt_sent), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic put_byte(input logic [7:0] d, input logic last);
    wr_en = 1'b1; wr_data = d; wr_last = last;
    tick();
    wr_en = 1'b0; wr_last = 1'b0;
  endtask

  task automatic request();
    tx_req = 1'b1;
    tick();
    tx_req = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
    chk({tag, "_start"}, 32'(tx_start_en), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_sent"}, 32'(pkt_sent), 32'd0);
    chk({tag, "_tmo"}, 32'(timeout_err), 32'd0);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    rst_n = 1'b1;
    chk_idle("rst");
    chk("rst_bytes", 32'(tx_byte_num), 32'd0);
    chk("rst_data", tx_data, 32'd0);

    // 8-byte packet, spaced requests
    for (int i = 1; i <= 8; i++) put_byte(8'(i), i == 8);
    chk("a_start", 32'(tx_start_en), 32'd1);
    chk("a_bytes", 32'(tx_byte_num), 32'd8);
    chk("a_wr_ready", 32'(wr_ready), 32'd0);
    chk("a_busy", 32'(busy), 32'd1);
    tick();
    chk("a_start_off", 32'(tx_start_en), 32'd0);
    request();
    chk("a_word0", tx_data, 32'h01020304);
    tick(); tick();
    request();
    chk("a_word1", tx_data, 32'h05060708);
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    chk("a_sent", 32'(pkt_sent), 32'd1);
    chk("a_ready", 32'(wr_ready), 32'd1);
    chk("a_bytes_hold", 32'(tx_byte_num), 32'd8);
    tick();
    chk("a_sent_off", 32'(pkt_sent), 32'd0);

    // 6-byte packet: zero-padded tail and an over-request
    put_byte(8'hAA, 1'b0);
    chk("b_bytes_clr", 32'(tx_byte_num), 32'd0);
    put_byte(8'hBB, 1'b0); put_byte(8'hCC, 1'b0);
    put_byte(8'hDD, 1'b0); put_byte(8'hEE, 1'b0);
    put_byte(8'hFF, 1'b1);
    chk("b_bytes", 32'(tx_byte_num), 32'd6);
    tick();
    request();
    chk("b_word0", tx_data, 32'hAABBCCDD);
    request();
    chk("b_word1", tx_data, 32'hEEFF0000);
    request();
    chk("b_over", tx_data, 32'h00000000);
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    chk("b_sent", 32'(pkt_sent), 32'd1);

    // Timeout with no tx_done
    put_byte(8'h11, 1'b0); put_byte(8'h22, 1'b0);
    put_byte(8'h33, 1'b0); put_byte(8'h44, 1'b1);
    tick();
    for (int i = 0; i < 19; i++) tick();
    chk("t_not_yet", 32'(timeout_err), 32'd0);
    chk("t_busy", 32'(busy), 32'd1);
    tick();
    chk("t_tmo", 32'(timeout_err), 32'd1);
    chk("t_no_sent", 32'(pkt_sent), 32'd0);
    chk("t_ready", 32'(wr_ready), 32'd1);
    tick();
    chk("t_tmo_off", 32'(timeout_err), 32'd0);

    // tx_done with tx_req together; then tx_done while filling
    for (int i = 0; i < 8; i++) put_byte(8'h10 + 8'(i), i == 7);
    tick();
    request();
    chk("d_word0", tx_data, 32'h10111213);
    tx_req = 1'b1; tx_done = 1'b1; tick(); tx_req = 1'b0; tx_done = 1'b0;
    chk("d_sent", 32'(pkt_sent), 32'd1);
    chk("d_data_hold", tx_data, 32'h10111213);
    chk("d_fill", 32'(busy), 32'd0);
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    chk_idle("d_done_in_fill");

    // Reset mid-SEND, then a normal 4-byte packet
    put_byte(8'h55, 1'b0); put_byte(8'h66, 1'b0);
    put_byte(8'h77, 1'b0); put_byte(8'h88, 1'b1);
    tick();
    request();
    chk("r_word0", tx_data, 32'h55667788);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk_idle("r_after");
    chk("r_data", tx_data, 32'd0);
    chk("r_bytes", 32'(tx_byte_num), 32'd0);
    put_byte(8'hA1, 1'b0); put_byte(8'hA2, 1'b0);
    put_byte(8'hA3, 1'b0); put_byte(8'hA4, 1'b1);
    chk("r_start", 32'(tx_start_en), 32'd1);
    chk("r_bytes4", 32'(tx_byte_num), 32'd4);
    tick();
    request();
    chk("r_word", tx_data, 32'hA1A2A3A4);
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    chk("r_sent", 32'(pkt_sent), 32'd1);

    // Fill the 16-byte buffer without last
    for (int i = 0; i < 15; i++) put_byte(8'h20 + 8'(i), 1'b0);
    chk("f_ready15", 32'(wr_ready), 32'd1);
    put_byte(8'h2F, 1'b0);
    chk("f_full", 32'(wr_ready), 32'd0);
    put_byte(8'h99, 1'b1);
    chk("f_no_start", 32'(tx_start_en), 32'd0);
    chk("f_no_busy", 32'(busy), 32'd0);
    chk("f_bytes", 32'(tx_byte_num), 32'd0);
    chk("f_still_full", 32'(wr_ready), 32'd0);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("f_rst_ready", 32'(wr_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
